dmem_lsu: RTL



---
 rtl/dmem_pkg.sv | 37 +++
 rtl/dmem_load_align.sv | 23 ++
 rtl/dmem_lsu.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and helpers for the data-memory load/store unit
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACC_HI = 2'd1,
    RESP   = 2'd2
  } state_e;

  function automatic logic [3:0] size_mask(input logic [1:0] size);
    case (size)
      SZ_B:    size_mask = MASK_B;
      SZ_H:    size_mask = MASK_H;
      SZ_W:    size_mask = MASK_W;
      default: size_mask = 4'b0000;
    endcase
  endfunction

  // True when the access spills past byte 3 into the next word.
  function automatic logic straddles(input logic [1:0] offset, input logic [1:0] size);
    case (size)
      SZ_H:    straddles = (offset == 2'd3);
      SZ_W:    straddles = (offset != 2'd0);
      default: straddles = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// rtl/dmem_load_align.sv - extracts and extends load data from a two-word window
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [63:0] data,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] rdata
);

  logic [31:0] win;

  always_comb begin
    win = data[{offset, 3'b000} +: 32];
    case (size)
      SZ_B:    rdata = {{24{sign & win[7]}}, win[7:0]};
      SZ_H:    rdata = {{16{sign & win[15]}}, win[15:0]};
      default: rdata = win;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - byte-enabled data RAM with misaligned access splitting
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int RAM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(DEPTH_WORDS);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rd_q;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [1:0]         off_q, off_d;
  logic [1:0]         size_q, size_d;
  logic               signed_q, signed_d;
  logic               we_q, we_d;
  logic               strad_q, strad_d;
  logic [31:0]        wdata_hi_q, wdata_hi_d;
  logic [3:0]         be_hi_q, be_hi_d;
  logic [31:0]        lo_q, lo_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_err_q, resp_err_d;

  logic [IDX_W-1:0]   req_idx;
  logic [63:0]        lane;
  logic [7:0]         be;
  logic               lo_oob, hi_oob;
  logic [IDX_W:0]     idx_hi;

  logic               ram_en, ram_we;
  logic [RAM_AW-1:0]  ram_addr;
  logic [31:0]        ram_wdata;
  logic [3:0]         ram_be;

  logic [31:0]        ld_data;

  assign req_idx = req_addr[ADDR_W-1:2];
  assign lane    = {32'b0, req_wdata} << {req_addr[1:0], 3'b000};
  assign be      = {4'b0, size_mask(req_size)} << req_addr[1:0];
  assign lo_oob  = {1'b0, req_idx} >= DEPTH_L;
  assign idx_hi  = {1'b0, idx_q} + (IDX_W + 1)'(1);
  assign hi_oob  = idx_hi >= DEPTH_L;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    off_d        = off_q;
    size_d       = size_q;
    signed_d     = signed_q;
    we_d         = we_q;
    strad_d      = strad_q;
    wdata_hi_d   = wdata_hi_q;
    be_hi_d      = be_hi_q;
    lo_d         = lo_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = '0;
    ram_wdata    = '0;
    ram_be       = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          idx_d      = req_idx;
          off_d      = req_addr[1:0];
          size_d     = req_size;
          signed_d   = req_signed;
          we_d       = req_we;
          strad_d    = straddles(req_addr[1:0], req_size);
          wdata_hi_d = lane[63:32];
          be_hi_d    = be[7:4];
          if (req_size == SZ_X || lo_oob) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end else begin
            ram_en    = 1'b1;
            ram_we    = req_we;
            ram_addr  = req_idx[RAM_AW-1:0];
            ram_wdata = lane[31:0];
            ram_be    = be[3:0];
            if (straddles(req_addr[1:0], req_size)) begin
              state_d = ACC_HI;
            end else begin
              state_d      = RESP;
              resp_valid_d = 1'b1;
            end
          end
        end
      end
      ACC_HI: begin
        lo_d         = rd_q;
        state_d      = RESP;
        resp_valid_d = 1'b1;
        // A low-word store has already landed even if the high word is out of range.
        if (hi_oob) begin
          resp_err_d = 1'b1;
        end else begin
          ram_en    = 1'b1;
          ram_we    = we_q;
          ram_addr  = idx_hi[RAM_AW-1:0];
          ram_wdata = wdata_hi_q;
          ram_be    = be_hi_q;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      off_q        <= '0;
      size_q       <= '0;
      signed_q     <= 1'b0;
      we_q         <= 1'b0;
      strad_q      <= 1'b0;
      wdata_hi_q   <= '0;
      be_hi_q      <= '0;
      lo_q         <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      off_q        <= off_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      we_q         <= we_d;
      strad_q      <= strad_d;
      wdata_hi_q   <= wdata_hi_d;
      be_hi_q      <= be_hi_d;
      lo_q         <= lo_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // RAM is not reset; reset only suppresses new accesses.
  always_ff @(posedge clk) begin
    if (ram_en && rst_n) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++) begin
          if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
      end else begin
        rd_q <= mem[ram_addr];
      end
    end
  end

  dmem_load_align u_align (
    .data   (strad_q ? {rd_q, lo_q} : {32'b0, rd_q}),
    .offset (off_q),
    .size   (size_q),
    .sign   (signed_q),
    .rdata  (ld_data)
  );

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = (resp_valid_q && !resp_err_q && !we_q) ? ld_data : 32'b0;

endmodule
